// File: rtl/branch_resolver.sv
// branch_resolver
//   Keeps the S/Z/C/V flag register that the ALU Outcond bus writes. Resolves
//   simple conditional branches against those flags, one branch at a time. It
//   reports taken/not-taken as a one-cycle pulse. For a taken branch it holds
//   a PC redirect toward fetch until fetch acknowledges it.
//
//   Optional feature: define FLAG_BYPASS_EN. Then a flag write in the EVAL
//   cycle (flag_we=1) is forwarded into the condition evaluation. Without it,
//   evaluation always uses the registered flags.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   flag_we/flag_in flag register write {S,Z,C,V}
//   flags_out       current flag register
//   br_valid/br_ready, br_cond, br_disp, pc_in   branch offer from decode
//   flush           abort the branch in flight
//   resolve_valid/taken                          one-cycle resolution pulse
//   redirect_valid/redirect_pc/redirect_ack      redirect handshake to fetch
module branch_resolver #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned DISP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [3:0]        flag_in,
  output logic [3:0]        flags_out,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [DISP_W-1:0] br_disp,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              flush,
  output logic              resolve_valid,
  output logic              taken,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  input  logic              redirect_ack
);

  typedef enum logic [1:0] {StIdle, StEval, StRedirect} state_e;

  state_e              state_q, state_d;
  logic [3:0]          flags_q;
  logic [2:0]          cond_q;
  logic [DISP_W-1:0]   disp_q;
  logic [PC_W-1:0]     pc_q;
  logic                resolve_q, resolve_d;
  logic                taken_q, taken_d;
  logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
  logic                latch_en;

  logic                eval_s, eval_z, eval_v;
  logic                cond_met;
  logic [PC_W-1:0]     disp_ext;
  logic [PC_W-1:0]     target;

  // Flags that the condition sees. The register itself is updated the same
  // way in both variants.
`ifdef FLAG_BYPASS_EN
  assign eval_s = flag_we ? flag_in[3] : flags_q[3];
  assign eval_z = flag_we ? flag_in[2] : flags_q[2];
  assign eval_v = flag_we ? flag_in[0] : flags_q[0];
`else
  assign eval_s = flags_q[3];
  assign eval_z = flags_q[2];
  assign eval_v = flags_q[0];
`endif

  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      3'b000:  cond_met = eval_z;
      3'b001:  cond_met = eval_s ^ eval_v;
      3'b010:  cond_met = eval_z | (eval_s ^ eval_v);
      3'b011:  cond_met = ~eval_z;
      3'b100:  cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // The target wraps modulo 2^PC_W.
  assign disp_ext = {{(PC_W-DISP_W){disp_q[DISP_W-1]}}, disp_q};
  assign target   = pc_q + PC_W'(1) + disp_ext;

  always_comb begin
    state_d       = state_q;
    resolve_d     = 1'b0;
    taken_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    latch_en      = 1'b0;
    case (state_q)
      StIdle: begin
        // flush in IDLE blocks acceptance for that cycle.
        if (br_valid && !flush) begin
          latch_en = 1'b1;
          state_d  = StEval;
        end
      end
      StEval: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          resolve_d = 1'b1;
          taken_d   = cond_met;
          if (cond_met) begin
            redirect_pc_d = target;
            state_d       = StRedirect;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRedirect: begin
        if (flush || redirect_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      flags_q       <= 4'b0000;
      cond_q        <= 3'b000;
      disp_q        <= '0;
      pc_q          <= '0;
      resolve_q     <= 1'b0;
      taken_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      resolve_q     <= resolve_d;
      taken_q       <= taken_d;
      redirect_pc_q <= redirect_pc_d;
      if (flag_we) flags_q <= flag_in;
      if (latch_en) begin
        cond_q <= br_cond;
        disp_q <= br_disp;
        pc_q   <= pc_in;
      end
    end
  end

  assign flags_out      = flags_q;
  assign br_ready       = (state_q == StIdle);
  assign resolve_valid  = resolve_q;
  assign taken          = taken_q;
  assign redirect_valid = (state_q == StRedirect);
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flag_we = 1'b0;
  logic [3:0]  flag_in = 4'b0;
  logic [3:0]  flags_out;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  br_cond = 3'b0;
  logic [7:0]  br_disp = 8'h0;
  logic [15:0] pc_in = 16'h0;
  logic        flush = 1'b0;
  logic        resolve_valid;
  logic        taken;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        redirect_ack = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  branch_resolver #(.PC_W(16), .DISP_W(8)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in), .flags_out(flags_out),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_disp(br_disp),
    .pc_in(pc_in), .flush(flush), .resolve_valid(resolve_valid), .taken(taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1;
    flag_in = f;
    step();
    flag_we = 1'b0;
  endtask

  // Offer a branch for one cycle; returns in the EVAL cycle.
  task automatic offer(input logic [2:0] c, input logic [15:0] p, input logic [7:0] d);
    br_valid = 1'b1;
    br_cond  = c;
    pc_in    = p;
    br_disp  = d;
    step();
    br_valid = 1'b0;
  endtask

  task automatic ack();
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total_cnt++;
    if ({br_ready, resolve_valid, taken, redirect_valid} !== 4'b1000)
      $display("FAIL reset_ctl got=%b exp=1000",
               {br_ready, resolve_valid, taken, redirect_valid});
    else pass_cnt++;
    total_cnt++;
    if ({flags_out, redirect_pc} !== 20'h0)
      $display("FAIL reset_regs got=%h exp=00000", {flags_out, redirect_pc});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_be_taken();
    flag_we = 1'b1;
    flag_in = 4'b0100;
    offer(3'b000, 16'h0010, 8'h05);
    flag_we = 1'b0;
    total_cnt++;
    if ({br_ready, resolve_valid, flags_out} !== 6'b00_0100)
      $display("FAIL be_eval got=%b exp=000100", {br_ready, resolve_valid, flags_out});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({resolve_valid, taken, redirect_valid, redirect_pc} !== {3'b111, 16'h0016})
      $display("FAIL be_resolve got=%b/%h exp=111/0016",
               {resolve_valid, taken, redirect_valid}, redirect_pc);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({resolve_valid, redirect_valid, redirect_pc} !== {2'b01, 16'h0016})
      $display("FAIL be_hold got=%b/%h exp=01/0016", {resolve_valid, redirect_valid},
               redirect_pc);
    else pass_cnt++;
    ack();
    total_cnt++;
    if ({redirect_valid, br_ready} !== 2'b01)
      $display("FAIL be_ack got=%b exp=01", {redirect_valid, br_ready});
    else pass_cnt++;
  endtask

  task automatic test_blt_ble();
    set_flags(4'b1000);
    offer(3'b001, 16'h0100, 8'h10);
    step();
    total_cnt++;
    if ({resolve_valid, taken, redirect_pc} !== {2'b11, 16'h0111})
      $display("FAIL blt_taken got=%b/%h exp=11/0111", {resolve_valid, taken}, redirect_pc);
    else pass_cnt++;
    ack();
    offer(3'b010, 16'h0200, 8'hFF);
    step();
    total_cnt++;
    if ({resolve_valid, taken, redirect_pc} !== {2'b11, 16'h0200})
      $display("FAIL ble_taken got=%b/%h exp=11/0200", {resolve_valid, taken}, redirect_pc);
    else pass_cnt++;
    ack();
    set_flags(4'b1001);
    offer(3'b001, 16'h0300, 8'h04);
    step();
    total_cnt++;
    if ({resolve_valid, taken, redirect_valid, br_ready} !== 4'b1001)
      $display("FAIL blt_untaken got=%b exp=1001",
               {resolve_valid, taken, redirect_valid, br_ready});
    else pass_cnt++;
    // Reserved code, accepted back-to-back right after the untaken resolve.
    offer(3'b101, 16'h0400, 8'h04);
    step();
    total_cnt++;
    if ({resolve_valid, taken, redirect_valid} !== 3'b100)
      $display("FAIL cond_reserved got=%b exp=100", {resolve_valid, taken, redirect_valid});
    else pass_cnt++;
    set_flags(4'b0000);
    offer(3'b011, 16'h0500, 8'h02);
    step();
    total_cnt++;
    if ({resolve_valid, taken, redirect_pc} !== {2'b11, 16'h0503})
      $display("FAIL bne_taken got=%b/%h exp=11/0503", {resolve_valid, taken}, redirect_pc);
    else pass_cnt++;
    ack();
  endtask

  task automatic test_wrap();
    offer(3'b100, 16'hFFFE, 8'h01);
    step();
    total_cnt++;
    if ({taken, redirect_valid, redirect_pc} !== {2'b11, 16'h0000})
      $display("FAIL wrap_up got=%b/%h exp=11/0000", {taken, redirect_valid}, redirect_pc);
    else pass_cnt++;
    ack();
    redirect_ack = 1'b0;
    offer(3'b100, 16'h0003, 8'hFC);
    step();
    total_cnt++;
    if ({taken, redirect_pc} !== {1'b1, 16'h0000})
      $display("FAIL wrap_neg got=%b/%h exp=1/0000", taken, redirect_pc);
    else pass_cnt++;
    ack();
  endtask

  task automatic test_hazard();
    logic exp_taken;
`ifdef FLAG_BYPASS_EN
    exp_taken = 1'b1;
`else
    exp_taken = 1'b0;
`endif
    set_flags(4'b0000);
    offer(3'b000, 16'h0020, 8'h00);
    flag_we = 1'b1;
    flag_in = 4'b0100;
    step();
    flag_we = 1'b0;
    total_cnt++;
    if ({resolve_valid, taken, flags_out} !== {1'b1, exp_taken, 4'b0100})
      $display("FAIL hazard got=%b%b/%b exp=1%b/0100", resolve_valid, taken, flags_out,
               exp_taken);
    else pass_cnt++;
    if (exp_taken) ack();
  endtask

  task automatic test_hold_ack();
    offer(3'b100, 16'h1000, 8'h7F);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if ({redirect_valid, br_ready, resolve_valid, redirect_pc} !== {3'b100, 16'h1080})
        $display("FAIL hold_%0d got=%b/%h exp=100/1080", i,
                 {redirect_valid, br_ready, resolve_valid}, redirect_pc);
      else pass_cnt++;
    end
    ack();
    total_cnt++;
    if ({redirect_valid, br_ready} !== 2'b01)
      $display("FAIL hold_ack got=%b exp=01", {redirect_valid, br_ready});
    else pass_cnt++;
  endtask

  task automatic test_abort();
    set_flags(4'b1111);
    offer(3'b100, 16'h0040, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({resolve_valid, redirect_valid, br_ready, flags_out} !== 7'b001_0000)
      $display("FAIL rst_eval got=%b exp=0010000",
               {resolve_valid, redirect_valid, br_ready, flags_out});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({resolve_valid, redirect_valid} !== 2'b00)
      $display("FAIL rst_after got=%b exp=00", {resolve_valid, redirect_valid});
    else pass_cnt++;
    offer(3'b100, 16'h0050, 8'h01);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++;
    if ({resolve_valid, redirect_valid, br_ready} !== 3'b001)
      $display("FAIL flush_redir got=%b exp=001", {resolve_valid, redirect_valid, br_ready});
    else pass_cnt++;
    // flush in IDLE blocks the same-cycle offer.
    flush = 1'b1;
    offer(3'b100, 16'h0060, 8'h01);
    flush = 1'b0;
    total_cnt++;
    if (br_ready !== 1'b1)
      $display("FAIL flush_idle got=%b exp=1", br_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({resolve_valid, redirect_valid} !== 2'b00)
      $display("FAIL flush_idle_nores got=%b exp=00", {resolve_valid, redirect_valid});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_be_taken();
    test_blt_ble();
    test_wrap();
    test_hazard();
    test_hold_ack();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
